// File: rtl/cpu24_pkg.sv
// Shared widths and dump FSM encoding for the 24-bit CPU register file and
// its dump reader.
package cpu24_pkg;

  localparam int CPU_DATA_WIDTH = 24;
  localparam int REG_ADDR_WIDTH = 4;
  localparam int NUM_REGS       = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dumpState_t;

endpackage

// File: rtl/register_dump_reader_if.sv
// Valid/ready stream carrying one (register index, register contents) beat.
interface register_dump_reader_if #(
  parameter int DATA_WIDTH = cpu24_pkg::CPU_DATA_WIDTH,
  parameter int ADDR_WIDTH = cpu24_pkg::REG_ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] DumpAddr;
  logic [DATA_WIDTH-1:0] DumpData;
  logic                  DumpValid;
  logic                  DumpReady;

  modport master (
    output DumpAddr, DumpData, DumpValid,
    input  DumpReady
  );

  modport slave (
    input  DumpAddr, DumpData, DumpValid,
    output DumpReady
  );

endinterface

// File: rtl/register_dump_reader.sv
// Walks the register file read port over [FIRST_REG, LAST_REG] and emits each
// register as an (address, data) beat on a valid/ready stream.
//
//   state | meaning
//   IDLE  | waiting for Start; stream quiet
//   ADDR  | RS driven, register file output settling for one cycle
//   SEND  | beat presented, waiting for DumpReady
//   DONE  | one-cycle Done pulse after the last accepted beat
module register_dump_reader
  import cpu24_pkg::*;
#(
  parameter int DATA_WIDTH = CPU_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int FIRST_REG  = 0,
  parameter int LAST_REG   = NUM_REGS - 1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Abort,
  output logic [ADDR_WIDTH-1:0]  RS,
  input  logic [DATA_WIDTH-1:0]  ReadRS,
  register_dump_reader_if.master dump,
  output logic                   Busy,
  output logic                   Done
);

  localparam logic [ADDR_WIDTH-1:0] firstAddr = ADDR_WIDTH'(FIRST_REG);
  localparam logic [ADDR_WIDTH-1:0] lastAddr  = ADDR_WIDTH'(LAST_REG);

  dumpState_t state;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state          <= IDLE;
      RS             <= '0;
      dump.DumpAddr  <= '0;
      dump.DumpData  <= '0;
      dump.DumpValid <= 1'b0;
      Done           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dump.DumpValid <= 1'b0;
          Done           <= 1'b0;
          if (Start) begin
            RS    <= firstAddr;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (Abort) begin
            dump.DumpValid <= 1'b0;
            state          <= IDLE;
          end else begin
            // Snapshot taken here: a same-edge write is not seen.
            dump.DumpData  <= ReadRS;
            dump.DumpAddr  <= RS;
            dump.DumpValid <= 1'b1;
            state          <= SEND;
          end
        end
        SEND: begin
          // Abort wins over a simultaneous handshake; the beat is dropped.
          if (Abort) begin
            dump.DumpValid <= 1'b0;
            state          <= IDLE;
          end else if (dump.DumpReady) begin
            dump.DumpValid <= 1'b0;
            if (RS == lastAddr) begin
              Done  <= 1'b1;
              state <= DONE;
            end else begin
              RS    <= RS + 1'b1;
              state <= ADDR;
            end
          end
        end
        DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy = (state == ADDR) || (state == SEND);

endmodule

// File: tb/tb_register_dump_reader.sv
// Directed bench for register_dump_reader: a behavioural register file feeds
// two dump readers, one over the full range and one over registers 2..3.
module tb_register_dump_reader;
  import cpu24_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, startA, startB, abortA, regWrite;
  logic [3:0]  writeAddr;
  logic [23:0] writeData;
  logic [23:0] regs [NUM_REGS];
  logic [3:0]  rsA, rsB;
  logic [23:0] readRsA, readRsB;
  logic        busyA, doneA, busyB, doneB;

  int checks = 0;
  int errors = 0;

  register_dump_reader_if dumpA ();
  register_dump_reader_if dumpB ();

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (regWrite) begin
      regs[writeAddr] <= writeData;
    end
  end

  assign readRsA = regs[rsA];
  assign readRsB = regs[rsB];

  register_dump_reader dutA (
    .Clock (clk), .Reset (reset), .Start (startA), .Abort (abortA),
    .RS (rsA), .ReadRS (readRsA), .dump (dumpA.master),
    .Busy (busyA), .Done (doneA)
  );

  register_dump_reader #(.FIRST_REG(2), .LAST_REG(3)) dutB (
    .Clock (clk), .Reset (reset), .Start (startB), .Abort (1'b0),
    .RS (rsB), .ReadRS (readRsB), .dump (dumpB.master),
    .Busy (busyB), .Done (doneB)
  );

  task automatic writeReg(input logic [3:0] a, input logic [23:0] d);
    @(negedge clk);
    regWrite = 1'b1; writeAddr = a; writeData = d;
    @(negedge clk);
    regWrite = 1'b0;
  endtask

  task automatic pulseStartA();
    @(negedge clk);
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
  endtask

  task automatic waitBeatA(input logic [3:0] addr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dumpA.DumpValid && dumpA.DumpAddr == addr) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitDoneA(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (doneA) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; startA = 1'b1; startB = 1'b1; abortA = 1'b0; regWrite = 1'b0;
    writeAddr = '0; writeData = '0;
    dumpA.DumpReady = 1'b0; dumpB.DumpReady = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsA !== 4'd0 || dumpA.DumpValid !== 1'b0 || busyA !== 1'b0 || doneA !== 1'b0 ||
        dumpA.DumpAddr !== 4'd0 || dumpA.DumpData !== 24'd0)
      begin errors++; $display("FAIL reset_state: rs=%0d valid=%b busy=%b done=%b addr=%0d data=%0d, required all 0",
                               rsA, dumpA.DumpValid, busyA, doneA, dumpA.DumpAddr, dumpA.DumpData); end
    reset = 1'b0; startA = 1'b0; startB = 1'b0;
    @(negedge clk);
    checks++;
    if (busyA !== 1'b0 || busyB !== 1'b0 || dumpA.DumpValid !== 1'b0)
      begin errors++; $display("FAIL reset_no_start: busyA=%b busyB=%b valid=%b, required 0 0 0",
                               busyA, busyB, dumpA.DumpValid); end
  endtask

  task automatic test_full_dump();
    int beats, dones, doneCyc;
    logic [23:0] expData;
    writeReg(4'd2, 24'd5);
    writeReg(4'd3, 24'd7);
    dumpA.DumpReady = 1'b1;
    pulseStartA();
    beats = 0; dones = 0; doneCyc = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (dumpA.DumpValid) begin
        expData = (beats == 2) ? 24'd5 : (beats == 3) ? 24'd7 : 24'd0;
        checks++;
        if (dumpA.DumpAddr !== 4'(beats) || dumpA.DumpData !== expData)
          begin errors++; $display("FAIL full_beat%0d: addr=%0d data=%0d, required addr=%0d data=%0d",
                                   beats, dumpA.DumpAddr, dumpA.DumpData, beats, expData); end
        beats++;
      end
      if (doneA) begin
        dones++; doneCyc = cyc;
        checks++;
        if (busyA !== 1'b0)
          begin errors++; $display("FAIL full_busy_at_done: busy=%b, required 0", busyA); end
      end
    end
    checks++;
    if (beats != 16) begin errors++; $display("FAIL full_beat_count: got %0d, required 16", beats); end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL full_done_count: got %0d, required 1", dones); end
    checks++;
    if (doneCyc != 32) begin errors++; $display("FAIL full_done_cycle: got %0d, required 32", doneCyc); end
  endtask

  task automatic test_backpressure();
    bit ok;
    dumpA.DumpReady = 1'b1;
    pulseStartA();
    waitBeatA(4'd3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_reach_beat3: timeout, required beat 3"); end
    dumpA.DumpReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (dumpA.DumpValid !== 1'b1 || dumpA.DumpAddr !== 4'd3 || dumpA.DumpData !== 24'd7 || rsA !== 4'd3)
        begin errors++; $display("FAIL bp_hold%0d: valid=%b addr=%0d data=%0d rs=%0d, required 1 3 7 3",
                                 i, dumpA.DumpValid, dumpA.DumpAddr, dumpA.DumpData, rsA); end
    end
    dumpA.DumpReady = 1'b1;
    @(negedge clk);
    checks++;
    if (dumpA.DumpValid !== 1'b0)
      begin errors++; $display("FAIL bp_after_handshake: valid=%b, required 0", dumpA.DumpValid); end
    @(negedge clk);
    checks++;
    if (dumpA.DumpValid !== 1'b1 || dumpA.DumpAddr !== 4'd4 || dumpA.DumpData !== 24'd0)
      begin errors++; $display("FAIL bp_beat4: valid=%b addr=%0d data=%0d, required 1 4 0",
                               dumpA.DumpValid, dumpA.DumpAddr, dumpA.DumpData); end
    waitDoneA(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_done: timeout, required Done"); end
  endtask

  task automatic test_range_restart();
    int beats, dones, doneCyc;
    logic [3:0]  expAddr;
    logic [23:0] expData;
    dumpB.DumpReady = 1'b1;
    for (int run = 0; run < 2; run++) begin
      @(negedge clk);
      startB = 1'b1;
      beats = 0; dones = 0; doneCyc = -1;
      for (int cyc = 0; cyc <= 12; cyc++) begin
        @(negedge clk);
        if (run == 1 && cyc == 0) startB = 1'b0;
        if (dumpB.DumpValid) begin
          expAddr = 4'(2 + beats);
          expData = (beats == 0) ? 24'd5 : 24'd7;
          checks++;
          if (beats >= 2 || dumpB.DumpAddr !== expAddr || dumpB.DumpData !== expData)
            begin errors++; $display("FAIL range_run%0d_beat%0d: addr=%0d data=%0d, required addr=%0d data=%0d (2 beats max)",
                                     run, beats, dumpB.DumpAddr, dumpB.DumpData, expAddr, expData); end
          beats++;
        end
        if (doneB) begin
          dones++; doneCyc = cyc;
          startB = 1'b0;
        end
      end
      checks++;
      if (beats != 2 || dones != 1 || doneCyc != 4)
        begin errors++; $display("FAIL range_run%0d_summary: beats=%0d dones=%0d doneCyc=%0d, required 2 1 4",
                                 run, beats, dones, doneCyc); end
    end
  endtask

  task automatic test_abort();
    bit ok;
    int badCycles;
    dumpA.DumpReady = 1'b1;
    pulseStartA();
    waitBeatA(4'd6, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_reach_beat6: timeout, required beat 6"); end
    abortA = 1'b1;
    @(negedge clk);
    abortA = 1'b0;
    checks++;
    if (dumpA.DumpValid !== 1'b0 || busyA !== 1'b0 || rsA !== 4'd6)
      begin errors++; $display("FAIL abort_next_cycle: valid=%b busy=%b rs=%0d, required 0 0 6",
                               dumpA.DumpValid, busyA, rsA); end
    badCycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (doneA !== 1'b0 || dumpA.DumpValid !== 1'b0 || busyA !== 1'b0) badCycles++;
    end
    checks++;
    if (badCycles != 0)
      begin errors++; $display("FAIL abort_quiet: %0d active cycles after abort, required 0", badCycles); end
  endtask

  task automatic test_write_collision();
    bit ok;
    ok = 1'b0;
    dumpA.DumpReady = 1'b1;
    pulseStartA();
    for (int i = 0; i < 100; i++) begin
      if (busyA && !dumpA.DumpValid && rsA == 4'd5) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL collide_reach_addr5: timeout, required ADDR with RS=5"); end
    regWrite = 1'b1; writeAddr = 4'd5; writeData = 24'd9;
    @(negedge clk);
    regWrite = 1'b0;
    checks++;
    if (dumpA.DumpValid !== 1'b1 || dumpA.DumpAddr !== 4'd5 || dumpA.DumpData !== 24'd0)
      begin errors++; $display("FAIL collide_beat5: valid=%b addr=%0d data=%0d, required 1 5 0",
                               dumpA.DumpValid, dumpA.DumpAddr, dumpA.DumpData); end
    waitDoneA(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL collide_done1: timeout, required Done"); end
    pulseStartA();
    waitBeatA(4'd5, ok);
    checks++;
    if (!ok || dumpA.DumpData !== 24'd9)
      begin errors++; $display("FAIL collide_redump5: found=%b data=%0d, required 1 9", ok, dumpA.DumpData); end
    waitDoneA(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL collide_done2: timeout, required Done"); end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_range_restart();
    test_abort();
    test_write_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
